// File: rtl/kernel_job_arbiter_if.sv
// Command-path bundle between the per-queue FWFT command FIFOs and the cl_box parser.
// Arbiter side uses the master modport; the queue/parser environment uses slave.
interface kernel_job_arbiter_if #(
  parameter int NUM_QUEUES = 4
);
  logic [32*NUM_QUEUES-1:0] q_cmd_dout;
  logic [NUM_QUEUES-1:0]    q_cmd_empty_n;
  logic [NUM_QUEUES-1:0]    q_cmd_rd_en;
  logic [31:0]              box_cmd_dout;
  logic                     box_cmd_empty_n;
  logic                     box_cmd_rd_en;

  modport master (
    input  q_cmd_dout, q_cmd_empty_n, box_cmd_rd_en,
    output q_cmd_rd_en, box_cmd_dout, box_cmd_empty_n
  );

  modport slave (
    output q_cmd_dout, q_cmd_empty_n, box_cmd_rd_en,
    input  q_cmd_rd_en, box_cmd_dout, box_cmd_empty_n
  );
endinterface

// File: rtl/kernel_job_arbiter.sv
// Round-robin owner of one compute kernel across NUM_QUEUES command queues; grant one clock after request.
// Granted queue is muxed combinationally to cl_box, so cl_box pops stall exactly with that queue's empty flag.
module kernel_job_arbiter #(
  parameter int NUM_QUEUES     = 4,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int QID_W          = $clog2(NUM_QUEUES)
) (
  input  logic                  axis_aclk,
  input  logic                  axis_rst,
  kernel_job_arbiter_if.master  cmd,
  input  logic                  cl_box_idle,
  input  logic                  cl_box_done,
  input  logic                  cl_kernel_idle,
  input  logic                  cl_kernel_done,
  output logic                  cl_box_start,
  output logic [QID_W-1:0]      grant_id,
  output logic                  busy,
  output logic                  timeout_err,
  output logic [31:0]           jobs_done_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BOX, S_KERNEL, S_RELEASE} state_t;

  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          WD_EN    = (TIMEOUT_CYCLES != 0);

  state_t           state;
  state_t           state_nxt;
  logic [QID_W-1:0] last_grant;
  logic [31:0]      wdog;
  logic [QID_W-1:0] pick;
  logic [QID_W-1:0] cand;
  logic             any_req;
  logic             wd_expire;
  logic             wd_abort;
  logic [31:0]      q_words [NUM_QUEUES];

  for (genvar i = 0; i < NUM_QUEUES; i++) begin : g_words
    assign q_words[i] = cmd.q_cmd_dout[32*i +: 32];
  end

  // Rotating search starting just after the previous owner.
  always_comb begin
    pick    = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_QUEUES; i++) begin
      cand = QID_W'((int'(last_grant) + 1 + i) % NUM_QUEUES);
      if (!any_req && cmd.q_cmd_empty_n[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  assign wd_expire = WD_EN && (wdog == WD_LIMIT);

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A done condition in the same cycle as expiry takes precedence over the abort.
  always_comb begin
    state_nxt = state;
    wd_abort  = 1'b0;
    case (state)
      S_IDLE: begin
        if (cl_box_idle && cl_kernel_idle && any_req) begin
          state_nxt = S_BOX;
        end
      end
      S_BOX: begin
        if (cl_box_done) begin
          state_nxt = cl_kernel_done ? S_RELEASE : S_KERNEL;
        end else if (wd_expire) begin
          state_nxt = S_RELEASE;
          wd_abort  = 1'b1;
        end
      end
      S_KERNEL: begin
        if (cl_kernel_done) begin
          state_nxt = S_RELEASE;
        end else if (wd_expire) begin
          state_nxt = S_RELEASE;
          wd_abort  = 1'b1;
        end
      end
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd.box_cmd_dout    = '0;
    cmd.box_cmd_empty_n = 1'b0;
    cmd.q_cmd_rd_en     = '0;
    if (state == S_BOX || state == S_KERNEL) begin
      cmd.box_cmd_dout          = q_words[grant_id];
      cmd.box_cmd_empty_n       = cmd.q_cmd_empty_n[grant_id];
      cmd.q_cmd_rd_en[grant_id] = cmd.box_cmd_rd_en && cmd.q_cmd_empty_n[grant_id];
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      cl_box_start  <= 1'b0;
      busy          <= 1'b0;
      grant_id      <= '0;
      timeout_err   <= 1'b0;
      jobs_done_cnt <= '0;
      wdog          <= '0;
      last_grant    <= QID_W'(NUM_QUEUES - 1);
    end else begin
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (state_nxt == S_BOX) begin
            grant_id     <= pick;
            busy         <= 1'b1;
            cl_box_start <= 1'b1;
            wdog         <= '0;
          end
        end
        S_BOX, S_KERNEL: begin
          wdog <= wdog + 32'd1;
          if (state_nxt != state) begin
            cl_box_start <= 1'b0;
          end
          if (wd_abort) begin
            timeout_err <= 1'b1;
          end
        end
        S_RELEASE: begin
          last_grant    <= grant_id;
          jobs_done_cnt <= jobs_done_cnt + 32'd1;
          busy          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_job_arbiter.sv
// Bench for kernel_job_arbiter: directed tables and corner sequences, then a randomized run
// against a job-level reference model.
module tb_kernel_job_arbiter;
  localparam int NQ  = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        box_idle, kernel_idle, box_done, kernel_done;
  logic        box_start, busy, tmo_err;
  logic [1:0]  grant_id;
  logic [31:0] done_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kernel_job_arbiter_if #(.NUM_QUEUES(NQ)) bus ();

  kernel_job_arbiter #(.NUM_QUEUES(NQ), .TIMEOUT_CYCLES(TMO), .QID_W(2)) dut (
    .axis_aclk      (clk),
    .axis_rst       (rst),
    .cmd            (bus),
    .cl_box_idle    (box_idle),
    .cl_box_done    (box_done),
    .cl_kernel_idle (kernel_idle),
    .cl_kernel_done (kernel_done),
    .cl_box_start   (box_start),
    .grant_id       (grant_id),
    .busy           (busy),
    .timeout_err    (tmo_err),
    .jobs_done_cnt  (done_cnt)
  );

  typedef struct {
    logic [3:0] req;
    int         grant;
  } gvec_t;

  typedef struct {
    logic [3:0] empty_n;
    logic       rd;
    logic [3:0] exp_rd_en;
    logic       exp_empty_n;
  } mvec_t;

  gvec_t gt[12];
  mvec_t mv[6];

  // Reference model state: job owner (-1 when none) and its progress.
  int          m_owner, m_age, m_last, m_grant;
  bit          m_inbox, m_closing, m_tmo;
  logic [31:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_busy(input logic val);
    int n = 0;
    while (busy !== val && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_busy", 32'(busy), 32'(val));
  endtask

  task automatic run_job(input logic [3:0] mask, input int exp_grant);
    bus.q_cmd_empty_n = mask;
    wait_busy(1'b1);
    chk("grant", 32'(grant_id), 32'(exp_grant));
    chk("start_box", 32'(box_start), 32'd1);
    bus.q_cmd_empty_n = 4'b0000;
    box_done = 1'b1;
    @(negedge clk);
    box_done = 1'b0;
    chk("start_kernel", 32'(box_start), 32'd0);
    chk("grant_hold", 32'(grant_id), 32'(exp_grant));
    kernel_done = 1'b1;
    @(negedge clk);
    kernel_done = 1'b0;
    wait_busy(1'b0);
  endtask

  task automatic model_step();
    bit finish, to_kernel, found;
    if (rst) begin
      m_owner = -1; m_age = 0; m_last = NQ - 1; m_grant = 0;
      m_inbox = 0; m_closing = 0; m_tmo = 0; m_cnt = '0;
      return;
    end
    m_tmo = 0;
    if (m_owner >= 0 && m_closing) begin
      m_last = m_owner;
      m_cnt  = m_cnt + 1;
      m_owner = -1;
      m_closing = 0;
    end else if (m_owner >= 0) begin
      finish    = m_inbox ? (box_done && kernel_done) : kernel_done;
      to_kernel = m_inbox && box_done && !kernel_done;
      if (finish) m_closing = 1;
      else if (to_kernel) m_inbox = 0;
      else if (m_age == TMO - 1) begin
        m_closing = 1;
        m_tmo = 1;
      end
      m_age++;
    end else if (box_idle && kernel_idle && (bus.q_cmd_empty_n != 0)) begin
      found = 0;
      for (int k = 1; k <= NQ; k++) begin
        if (!found && bus.q_cmd_empty_n[(m_last + k) % NQ]) begin
          found = 1;
          m_owner = (m_last + k) % NQ;
        end
      end
      m_grant = m_owner; m_inbox = 1; m_age = 0; m_closing = 0;
    end
  endtask

  initial begin
    int pops;
    int dprob;
    bit active;
    logic [3:0] exp_rd;

    gt[0]  = '{4'b1111, 0}; gt[1]  = '{4'b1111, 1}; gt[2]  = '{4'b1111, 2};
    gt[3]  = '{4'b1111, 3}; gt[4]  = '{4'b1111, 0}; gt[5]  = '{4'b1000, 3};
    gt[6]  = '{4'b0011, 0}; gt[7]  = '{4'b0110, 1}; gt[8]  = '{4'b0001, 0};
    gt[9]  = '{4'b0100, 2}; gt[10] = '{4'b0101, 0}; gt[11] = '{4'b0010, 1};
    mv[0] = '{4'b1111, 1'b1, 4'b0100, 1'b1};
    mv[1] = '{4'b0100, 1'b1, 4'b0100, 1'b1};
    mv[2] = '{4'b1011, 1'b1, 4'b0000, 1'b0};
    mv[3] = '{4'b1111, 1'b0, 4'b0000, 1'b1};
    mv[4] = '{4'b0111, 1'b1, 4'b0100, 1'b1};
    mv[5] = '{4'b0000, 1'b1, 4'b0000, 1'b0};

    rst = 1'b1; box_idle = 1'b1; kernel_idle = 1'b1; box_done = 1'b0; kernel_done = 1'b0;
    bus.q_cmd_empty_n = 4'b1111; bus.box_cmd_rd_en = 1'b1;
    for (int i = 0; i < NQ; i++) bus.q_cmd_dout[32*i +: 32] = 32'hA000_0000 + 32'(i);
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(box_start), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_tmo", 32'(tmo_err), 0);
    chk("rst_cnt", done_cnt, 0);
    chk("rst_box_empty_n", 32'(bus.box_cmd_empty_n), 0);
    chk("rst_rd_en", 32'(bus.q_cmd_rd_en), 0);
    rst = 1'b0; bus.box_cmd_rd_en = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_job(gt[i].req, gt[i].grant);
      if (i == 4) chk("cnt_after_5", done_cnt, 32'd5);
    end
    chk("cnt_after_table", done_cnt, 32'd12);

    // Pop steering while queue 2 owns the kernel.
    bus.q_cmd_empty_n = 4'b0100;
    wait_busy(1'b1);
    chk("mux_grant", 32'(grant_id), 2);
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      bus.q_cmd_empty_n = mv[i].empty_n;
      bus.box_cmd_rd_en = mv[i].rd;
      #1;
      chk("mux_rd_en", 32'(bus.q_cmd_rd_en), 32'(mv[i].exp_rd_en));
      chk("mux_empty_n", 32'(bus.box_cmd_empty_n), 32'(mv[i].exp_empty_n));
      chk("mux_dout", bus.box_cmd_dout, 32'hA000_0002);
      if (bus.q_cmd_rd_en != 0) pops++;
      @(negedge clk);
    end
    chk("pop_count", 32'(pops), 3);

    // Both dones in one BOX cycle skip KERNEL.
    bus.q_cmd_empty_n = 4'b1111; bus.box_cmd_rd_en = 1'b1;
    box_done = 1'b1; kernel_done = 1'b1;
    @(negedge clk);
    box_done = 1'b0; kernel_done = 1'b0;
    chk("both_start", 32'(box_start), 0);
    chk("both_busy_release", 32'(busy), 1);
    chk("release_rd_en", 32'(bus.q_cmd_rd_en), 0);
    chk("release_empty_n", 32'(bus.box_cmd_empty_n), 0);
    @(negedge clk);
    chk("both_busy_idle", 32'(busy), 0);
    chk("idle_rd_en", 32'(bus.q_cmd_rd_en), 0);
    chk("both_cnt", done_cnt, 32'd13);
    bus.q_cmd_empty_n = 4'b0000; bus.box_cmd_rd_en = 1'b0;
    @(negedge clk);

    // Watchdog expiry with no done at all.
    bus.q_cmd_empty_n = 4'b0001;
    wait_busy(1'b1);
    bus.q_cmd_empty_n = 4'b0000;
    for (int n = 0; n < 18; n++) begin
      chk("wd_tmo", 32'(tmo_err), 32'(n == 16));
      chk("wd_busy", 32'(busy), 32'(n <= 16));
      @(negedge clk);
    end
    chk("wd_cnt", done_cnt, 32'd14);

    // Done coincident with expiry: no timeout pulse.
    bus.q_cmd_empty_n = 4'b0001;
    wait_busy(1'b1);
    bus.q_cmd_empty_n = 4'b0000;
    for (int n = 0; n < 18; n++) begin
      chk("tie_tmo", 32'(tmo_err), 0);
      chk("tie_busy", 32'(busy), 32'(n <= 16));
      box_done = (n == 15); kernel_done = (n == 15);
      @(negedge clk);
    end
    chk("tie_cnt", done_cnt, 32'd15);

    // Counter wrap.
    force dut.jobs_done_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.jobs_done_cnt;
    run_job(4'b0100, 2);
    chk("cnt_wrap", done_cnt, 32'd0);

    // Reset during KERNEL.
    bus.q_cmd_empty_n = 4'b0010;
    wait_busy(1'b1);
    box_done = 1'b1;
    @(negedge clk);
    box_done = 1'b0;
    bus.q_cmd_empty_n = 4'b1111; bus.box_cmd_rd_en = 1'b1;
    #1;
    chk("kern_rd_en", 32'(bus.q_cmd_rd_en), 32'b0010);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_start", 32'(box_start), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    chk("mid_rst_tmo", 32'(tmo_err), 0);
    chk("mid_rst_cnt", done_cnt, 0);
    chk("mid_rst_empty_n", 32'(bus.box_cmd_empty_n), 0);
    chk("mid_rst_rd_en", 32'(bus.q_cmd_rd_en), 0);
    rst = 1'b0; bus.box_cmd_rd_en = 1'b0;
    wait_busy(1'b1);
    chk("post_rst_grant", 32'(grant_id), 0);

    // Randomized run against the reference model.
    rst = 1'b1;
    @(negedge clk);
    model_step();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      dprob = ((c / 500) % 2 == 1) ? 3 : 25;
      rst = ($urandom_range(0, 299) == 0);
      bus.q_cmd_empty_n = 4'($urandom);
      for (int i = 0; i < NQ; i++) bus.q_cmd_dout[32*i +: 32] = $urandom;
      bus.box_cmd_rd_en = 1'($urandom);
      box_idle    = ($urandom_range(0, 7) != 0);
      kernel_idle = ($urandom_range(0, 7) != 0);
      box_done    = ($urandom_range(0, 99) < dprob);
      kernel_done = ($urandom_range(0, 99) < dprob);
      #1;
      active = (m_owner >= 0) && !m_closing;
      exp_rd = 4'b0000;
      if (active && bus.box_cmd_rd_en && bus.q_cmd_empty_n[m_owner]) exp_rd[m_owner] = 1'b1;
      chk("rnd_busy", 32'(busy), 32'(m_owner >= 0));
      chk("rnd_start", 32'(box_start), 32'((m_owner >= 0) && m_inbox && !m_closing));
      chk("rnd_grant", 32'(grant_id), 32'(m_grant));
      chk("rnd_tmo", 32'(tmo_err), 32'(m_tmo));
      chk("rnd_cnt", done_cnt, m_cnt);
      chk("rnd_empty_n", 32'(bus.box_cmd_empty_n), active ? 32'(bus.q_cmd_empty_n[m_owner]) : 32'd0);
      chk("rnd_dout", bus.box_cmd_dout, active ? bus.q_cmd_dout[32*m_owner +: 32] : 32'd0);
      chk("rnd_rd_en", 32'(bus.q_cmd_rd_en), 32'(exp_rd));
      model_step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, checks %0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "global timeout");
  end

endmodule
